// File: rtl/usrt_apb_ctrl.sv
// APB register front-end for the USRT link: register map, TX/RX holding bytes,
// uClk tick divider, serializer/deserializer sequencing and the interrupt.
module usrt_apb_ctrl #(
    parameter logic [7:0] BAUD_DEFAULT = 8'd79,
    parameter int         FRAME_BITS   = 11
) (
    input  logic        pClk,
    input  logic        pReset,
    input  logic        pSelect,
    input  logic        pEnable,
    input  logic        pWrite,
    input  logic [1:0]  pAddress,
    input  logic [7:0]  pWData,
    output logic [7:0]  pRData,
    output logic        pReady,
    output logic        pSlvErr,
    output logic        uClk,
    output logic [10:0] tx_frame,
    output logic        tx_load,
    output logic        tx_en,
    output logic        rx_en,
    input  logic [10:0] rx_frame,
    input  logic        rx_done,
    output logic        irq
);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_BAUD   = 2'd3;
    localparam logic [3:0] TICKS       = 4'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} txState_t;

    txState_t    state;
    logic [7:0]  baud;
    logic [7:0]  divCnt;
    logic        txEnable;
    logic        rxEnable;
    logic        irqEn;
    logic [7:0]  txHold;
    logic        holdFull;
    logic [7:0]  rxHold;
    logic        rxValid;
    logic        overrun;
    logic        parErr;
    logic        frameErr;
    logic        txLoad;
    logic        txEn;
    logic [10:0] txFrame;
    logic [3:0]  tickCnt;
    logic        irqReg;

    logic        access;
    logic        wrAcc;
    logic        rdAcc;
    logic        holdWr;
    logic        popNow;
    logic        baudWr;
    logic        txBusy;
    logic        rxAccept;
    logic        rxShapeOk;
    logic        rxParOk;
    logic [7:0]  status;

    assign access    = pSelect & pEnable;
    assign wrAcc     = access & pWrite;
    assign rdAcc     = access & ~pWrite;
    assign holdWr    = wrAcc && (pAddress == ADDR_DATA) && !holdFull;
    assign popNow    = rdAcc && (pAddress == ADDR_DATA) && rxValid;
    assign baudWr    = wrAcc && (pAddress == ADDR_BAUD);
    assign txBusy    = (state != IDLE);
    assign rxAccept  = rx_done & rxEnable;
    assign rxShapeOk = rx_frame[0] & ~rx_frame[10];
    assign rxParOk   = (rx_frame[9] == ^rx_frame[8:1]);
    assign status    = {2'b00, frameErr, parErr, overrun, rxValid, holdFull, txBusy};

    assign pReady   = access;
    assign uClk     = (divCnt == baud);
    assign tx_frame = txFrame;
    assign tx_load  = txLoad;
    assign tx_en    = txEn;
    assign rx_en    = rxEnable;
    assign irq      = irqReg;

    // Read data is driven only during a read access so the bus sees 0 otherwise.
    always_comb begin
        pRData  = 8'h00;
        pSlvErr = 1'b0;
        if (rdAcc) begin
            case (pAddress)
                ADDR_DATA: begin
                    pRData  = rxValid ? rxHold : 8'h00;
                    pSlvErr = ~rxValid;
                end
                ADDR_STATUS: pRData = status;
                ADDR_CTRL:   pRData = {5'b00000, irqEn, rxEnable, txEnable};
                default:     pRData = baud;
            endcase
        end else if (wrAcc && (pAddress == ADDR_DATA)) begin
            pSlvErr = holdFull;
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            divCnt <= 8'h00;
        end else if (baudWr || uClk) begin
            divCnt <= 8'h00;
        end else begin
            divCnt <= divCnt + 8'h01;
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            baud     <= BAUD_DEFAULT;
            txEnable <= 1'b0;
            rxEnable <= 1'b0;
            irqEn    <= 1'b0;
            txHold   <= 8'h00;
            rxHold   <= 8'h00;
            rxValid  <= 1'b0;
            overrun  <= 1'b0;
            parErr   <= 1'b0;
            frameErr <= 1'b0;
            irqReg   <= 1'b0;
        end else begin
            if (holdWr)
                txHold <= pWData;
            if (wrAcc && (pAddress == ADDR_CTRL))
                {irqEn, rxEnable, txEnable} <= pWData[2:0];
            if (baudWr)
                baud <= (pWData == 8'h00) ? 8'h01 : pWData;
            if (wrAcc && (pAddress == ADDR_STATUS)) begin
                if (pWData[5]) frameErr <= 1'b0;
                if (pWData[4]) parErr   <= 1'b0;
                if (pWData[3]) overrun  <= 1'b0;
            end
            if (popNow)
                rxValid <= 1'b0;
            // Receive events come last so a set wins over a same-cycle clear.
            if (rxAccept) begin
                if (!rxShapeOk) begin
                    frameErr <= 1'b1;
                end else if (!rxParOk) begin
                    parErr <= 1'b1;
                end else if (!rxValid || popNow) begin
                    rxHold  <= rx_frame[8:1];
                    rxValid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
            irqReg <= irqEn & (rxValid | (txEnable & ~holdFull) | overrun | parErr | frameErr);
        end
    end

    // TX sequencer; hold_full stays set through LOAD so a write there is refused.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state    <= IDLE;
            holdFull <= 1'b0;
            txLoad   <= 1'b0;
            txEn     <= 1'b0;
            txFrame  <= 11'h000;
            tickCnt  <= 4'h0;
        end else begin
            txLoad <= 1'b0;
            if (holdWr)
                holdFull <= 1'b1;
            case (state)
                IDLE: begin
                    if (holdFull && txEnable && uClk) begin
                        state   <= LOAD;
                        txLoad  <= 1'b1;
                        txFrame <= {1'b0, ^txHold, txHold, 1'b1};
                    end
                end
                LOAD: begin
                    holdFull <= 1'b0;
                    txEn     <= 1'b1;
                    tickCnt  <= 4'h0;
                    state    <= SEND;
                end
                SEND: begin
                    // Leaves one cycle after the last tick so the serializer sees tx_en on it.
                    if (!txEnable || (tickCnt == TICKS)) begin
                        txEn  <= 1'b0;
                        state <= IDLE;
                    end else if (uClk) begin
                        tickCnt <= tickCnt + 4'h1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
